// File: rtl/resp_sig_analyzer.sv
// resp_sig_analyzer: serial-response signature analyzer.
// After an accepted start, ignores y_in for WARMUP settle cycles, then
// compacts test_len response bits into a MISR and compares the result
// against a golden signature latched on the start edge.
module resp_sig_analyzer #(
   parameter int unsigned           SIG_W  = 16,
   parameter logic [SIG_W-1:0]      POLY   = SIG_W'(16'h1021),
   parameter logic [SIG_W-1:0]      SEED   = {SIG_W{1'b1}},
   parameter int unsigned           WARMUP = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [7:0]       test_len,
   input  logic [SIG_W-1:0] golden_sig,
   input  logic             y_in,
   output logic             busy,
   output logic             capture,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] signature
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WARMUP,
      S_COMPACT,
      S_DONE
   } state_e;

   // Warm-up counter holds WARMUP-1 down to 0; keep it at least one bit wide
   // so a zero or one-cycle warm-up still elaborates cleanly.
   localparam int unsigned       WCNT_W    = (WARMUP > 1) ? $clog2(WARMUP) : 1;
   localparam logic [WCNT_W-1:0] WARM_INIT = (WARMUP > 0) ? WCNT_W'(WARMUP - 1) : '0;

   state_e             r_state;
   state_e             w_state_nxt;
   logic [WCNT_W-1:0]  r_warm_cnt;
   logic [7:0]         r_comp_cnt;
   logic [7:0]         r_len;
   logic [SIG_W-1:0]   r_golden;
   logic [SIG_W-1:0]   r_sig;

   logic               w_accept;
   logic               w_warm_last;
   logic               w_comp_last;
   logic               w_fb;
   logic [SIG_W-1:0]   w_sig_nxt;
   logic [7:0]         w_start_comp_cnt;
   logic [7:0]         w_warm_comp_cnt;

   // Start is only honoured when no run is in flight.
   assign w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_warm_last = (r_warm_cnt == '0);
   assign w_comp_last = (r_comp_cnt == 8'd0);

   // Compaction counter preload: len-1 edges remain after the first one.
   // A zero length never enters COMPACT, so its preload is simply parked at 0.
   assign w_start_comp_cnt = (test_len == 8'd0) ? 8'd0 : (test_len - 8'd1);
   assign w_warm_comp_cnt  = (r_len == 8'd0) ? 8'd0 : (r_len - 8'd1);

   // One MISR step: shift left, fold in the polynomial when the outgoing bit
   // disagrees with the incoming response bit.
   assign w_fb      = r_sig[SIG_W-1] ^ y_in;
   assign w_sig_nxt = {r_sig[SIG_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      // NOTE: default first so every path assigns w_state_nxt and no latch
      // is inferred.
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               if (WARMUP != 0) begin
                  w_state_nxt = S_WARMUP;
               end else if (test_len == 8'd0) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_COMPACT;
               end
            end
         end
         S_WARMUP: begin
            if (w_warm_last) begin
               w_state_nxt = (r_len == 8'd0) ? S_DONE : S_COMPACT;
            end
         end
         S_COMPACT: begin
            if (w_comp_last) begin
               w_state_nxt = S_DONE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Run parameters: captured on the accepted start edge only, so changes
   // on test_len/golden_sig during a run are invisible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len    <= 8'd0;
         r_golden <= '0;
      end else if (w_accept) begin
         r_len    <= test_len;
         r_golden <= golden_sig;
      end
   end

   // Warm-up and compaction down-counters; each phase ends when its counter
   // reads zero on an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_warm_cnt <= '0;
         r_comp_cnt <= 8'd0;
      end else if (w_accept) begin
         r_warm_cnt <= WARM_INIT;
         r_comp_cnt <= (WARMUP == 0) ? w_start_comp_cnt : 8'd0;
      end else begin
         unique case (r_state)
            S_WARMUP: begin
               if (w_warm_last) begin
                  r_comp_cnt <= w_warm_comp_cnt;
               end else begin
                  r_warm_cnt <= r_warm_cnt - 1'b1;
               end
            end
            S_COMPACT: begin
               if (!w_comp_last) begin
                  r_comp_cnt <= r_comp_cnt - 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Signature register: seeded on start, updated only while compacting,
   // held in every other state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sig <= SEED;
      end else if (w_accept) begin
         r_sig <= SEED;
      end else if (r_state == S_COMPACT) begin
         r_sig <= w_sig_nxt;
      end
   end

   // Outputs come from state and registers only; y_in never reaches them
   // combinationally.
   assign busy      = (r_state == S_WARMUP) || (r_state == S_COMPACT);
   assign capture   = (r_state == S_COMPACT);
   assign done      = (r_state == S_DONE);
   assign pass      = (r_state == S_DONE) && (r_sig == r_golden);
   assign signature = r_sig;

`ifndef SYNTHESIS
   // Flag consistency checks.
   a_pass_needs_done : assert property (@(posedge clk) disable iff (!rst_n)
      pass |-> done);
   a_capture_is_busy : assert property (@(posedge clk) disable iff (!rst_n)
      capture |-> busy);
   a_done_not_busy   : assert property (@(posedge clk) disable iff (!rst_n)
      !(done && busy));
`endif

endmodule

// File: doc/resp_sig_analyzer.md
RESP_SIG_ANALYZER -- requirements
Module: resp_sig_analyzer

Interface
REQ-001 Parameter SIG_W, default 16: signature register width.
REQ-002 Parameter POLY, default 16'h1021: MISR feedback polynomial (x^16+x^12+x^5+1).
REQ-003 Parameter SEED, default 16'hFFFF: signature value loaded at every test start.
REQ-004 Parameter WARMUP, default 3: settle cycles during which y_in is ignored (the upstream circuit's three unreset flops).
REQ-005 clk  input  1  single clock, all state updates on posedge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  begin a test run; honoured only in IDLE or DONE.
REQ-008 test_len  input  8  number of compaction cycles, sampled on the accepted start edge.
REQ-009 golden_sig  input  SIG_W  expected signature, sampled on the accepted start edge.
REQ-010 y_in  input  1  serial response bit (Y output of the upstream sequential stage).
REQ-011 busy  output  1  high in WARMUP or COMPACT.
REQ-012 capture  output  1  high only in COMPACT (y_in being compacted this cycle).
REQ-013 done  output  1  high in DONE.
REQ-014 pass  output  1  signature == latched golden; valid only while done=1, else 0.
REQ-015 signature  output  SIG_W  current MISR contents.

Function
REQ-016 FSM SHALL have states IDLE, WARMUP, COMPACT, DONE; encoding free.
REQ-017 IDLE/DONE + start=1 at edge E0 -> WARMUP; signature<=SEED; len/golden latched; warmup counter<=WARMUP-1.
REQ-018 WARMUP SHALL last exactly WARMUP edges (E1..E_W); signature held; y_in ignored.
REQ-019 WARMUP exit: latched len=0 -> DONE; else COMPACT with compaction counter<=len-1.
REQ-020 WARMUP=0 SHALL be legal: start edge goes directly to COMPACT (or DONE if len=0).
REQ-021 COMPACT SHALL last exactly len edges (E_W+1..E_W+len); each edge: fb = signature[SIG_W-1] ^ y_in; signature <= {signature[SIG_W-2:0],1'b0} ^ (fb ? POLY : 0).
REQ-022 After last COMPACT edge -> DONE; done asserts after edge E_(W+len); total latency W+len cycles from start edge.
REQ-023 DONE SHALL hold signature, done=1, pass stable until reset or accepted start.
REQ-024 start while busy SHALL be ignored; test_len/golden_sig changes while busy SHALL have no effect.
REQ-025 start in DONE SHALL restart identically to IDLE (done drops after the start edge).
REQ-026 test_len=255 SHALL compact exactly 255 bits; counters SHALL not wrap early or late.
REQ-027 Outputs SHALL be registered or decoded from state only; no combinational path from y_in to any output.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, signature=SEED, busy=capture=done=pass=0, counters=0, independent of clk.
REQ-029 Reset mid-WARMUP or mid-COMPACT SHALL abort the run; no partial done/pass SHALL appear after release.
REQ-030 First accepted start SHALL be the first posedge with rst_n=1 and start=1.

Verification
REQ-031 Reset release, no start for 10 cycles -> state IDLE, signature=16'hFFFF, all flags 0.
REQ-032 start, len=0, golden=16'hFFFF, WARMUP=3 -> done=1 after 3rd edge following start edge, pass=1, signature=16'hFFFF.
REQ-033 start, len=1, y_in=0 on the compaction edge, golden=16'hEFDF -> signature=16'hEFDF, pass=1; repeat with y_in=1 -> signature=16'hFFFE, pass=0.
REQ-034 start, len=255, random y_in, start pulsed again mid-COMPACT -> ignored; done exactly 258 cycles after first start; signature matches reference model.
REQ-035 rst_n pulsed low during COMPACT (len=20, after 10 bits) -> outputs to reset values asynchronously; IDLE after release, done stays 0.
REQ-036 Back-to-back: start in DONE with new golden -> done drops next cycle, second run result independent of first.
